// File: rtl/fetch_stim_gen.sv
// Fetch-stimulus sequencer: holds core reset, issues NUM_REQ fetch PCs and captures each
// returned instruction. Define FETCH_STIM_LOG_EN to build the capture log; otherwise it is tied off.
module fetch_stim_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     RESET_CYCLES = 5,
    parameter int unsigned     NUM_REQ      = 4,
    parameter logic [XLEN-1:0] START_PC     = '0,
    parameter logic [XLEN-1:0] PC_STRIDE    = XLEN'(4),
    parameter int unsigned     GAP_CYCLES   = 2,
    parameter int unsigned     TIMEOUT      = 64,
    parameter int unsigned     LOG_DEPTH    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_core_rst,
    output logic [XLEN-1:0]              o_pc,
    output logic                         o_req,
    input  logic [XLEN-1:0]              i_instruction,
    input  logic                         i_ready,
    input  logic                         i_stall,
    output logic [XLEN-1:0]              o_last_instr,
    input  logic [$clog2(LOG_DEPTH)-1:0] i_log_rd_idx,
    output logic [XLEN-1:0]              o_log_rd_data,
    output logic [$clog2(LOG_DEPTH):0]   o_log_count,
    output logic                         o_log_ovf,
    output logic                         o_done,
    output logic                         o_timeout_err
);

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ + 1);
    localparam int unsigned LW     = $clog2(LOG_DEPTH);
    localparam int unsigned CW     = LW + 1;

    typedef enum logic [2:0] {StRstHold, StIssue, StWait, StGap, StDone, StErr} state_e;

    state_e            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [TMR_W-1:0]  r_timer;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [IDX_W-1:0]  r_req_idx;
    logic              r_core_rst;
    logic [XLEN-1:0]   r_pc;
    logic              r_req;
    logic [XLEN-1:0]   r_last_instr;
    logic              r_done;
    logic              r_timeout_err;
    logic              r_ready_q;

    logic w_capture;
    logic w_last_req;

    // Only a fresh rising edge of ready completes a fetch; a level held across ISSUE is ignored.
    assign w_capture  = (r_state == StWait) && i_ready && !r_ready_q;
    assign w_last_req = (r_req_idx == IDX_W'(NUM_REQ - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StRstHold;
            r_hold_cnt    <= '0;
            r_timer       <= '0;
            r_gap_cnt     <= '0;
            r_req_idx     <= '0;
            r_core_rst    <= 1'b1;
            r_pc          <= START_PC;
            r_req         <= 1'b0;
            r_last_instr  <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_ready_q     <= 1'b0;
        end else begin
            r_ready_q <= i_ready;
            unique case (r_state)
                StRstHold: begin
                    if (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        r_core_rst <= 1'b0;
                        r_state    <= StIssue;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                StIssue: begin
                    r_req   <= 1'b1;
                    r_timer <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    // Capture takes priority over a timeout expiring on the same edge.
                    if (w_capture) begin
                        r_last_instr <= i_instruction;
                        r_pc         <= r_pc + PC_STRIDE;
                        r_req_idx    <= r_req_idx + IDX_W'(1);
                        r_req        <= 1'b0;
                        if (w_last_req) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else if (GAP_CYCLES == 0) begin
                            r_state <= StIssue;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= StGap;
                        end
                    end else if (!i_stall) begin
                        if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                            r_done        <= 1'b1;
                            r_timeout_err <= 1'b1;
                            r_req         <= 1'b0;
                            r_state       <= StErr;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_state <= StIssue;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                StDone, StErr: begin
                end
                default: r_state <= StRstHold;
            endcase
        end
    end

    assign o_core_rst    = r_core_rst;
    assign o_pc          = r_pc;
    assign o_req         = r_req;
    assign o_last_instr  = r_last_instr;
    assign o_done        = r_done;
    assign o_timeout_err = r_timeout_err;

`ifdef FETCH_STIM_LOG_EN
    logic [XLEN-1:0] r_log [LOG_DEPTH];
    logic [LW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_log_count;
    logic            r_log_ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_log       <= '{default: '0};
            r_wr_ptr    <= '0;
            r_log_count <= '0;
            r_log_ovf   <= 1'b0;
        end else if (w_capture) begin
            r_log[r_wr_ptr] <= i_instruction;
            r_wr_ptr        <= r_wr_ptr + LW'(1);
            // A write into a full log overwrites the oldest entry.
            if (r_log_count == CW'(LOG_DEPTH)) begin
                r_log_ovf <= 1'b1;
            end else begin
                r_log_count <= r_log_count + CW'(1);
            end
        end
    end

    assign o_log_rd_data = r_log[i_log_rd_idx];
    assign o_log_count   = r_log_count;
    assign o_log_ovf     = r_log_ovf;
`else
    logic w_unused_rd_idx;
    assign w_unused_rd_idx = ^i_log_rd_idx;
    assign o_log_rd_data   = '0;
    assign o_log_count     = '0;
    assign o_log_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stim_gen.sv
// Scoreboard bench for fetch_stim_gen: directed fetch sequences on a default instance and a
// wrap instance (NUM_REQ=10, START_PC=0xFFFFFFFC); a monitor checks each req fall.
module tb_fetch_stim_gen;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        done;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q1[$];
    exp_t q2[$];

    // Default instance signals
    logic        rst1 = 1'b1;
    logic        core_rst1, req1, ovf1, done1, err1;
    logic [31:0] pc1, last1, rd_data1;
    logic [31:0] instr1 = '0;
    logic        ready1 = 1'b0;
    logic        stall1 = 1'b0;
    logic [2:0]  rd_idx1 = '0;
    logic [3:0]  cnt1;

    // Wrap instance signals
    logic        rst2 = 1'b1;
    logic        core_rst2, req2, ovf2, done2, err2;
    logic [31:0] pc2, last2, rd_data2;
    logic [31:0] instr2 = '0;
    logic        ready2 = 1'b0;
    logic [2:0]  rd_idx2 = '0;
    logic [3:0]  cnt2;

    fetch_stim_gen dut1 (
        .i_clk         (clk),
        .i_rst         (rst1),
        .o_core_rst    (core_rst1),
        .o_pc          (pc1),
        .o_req         (req1),
        .i_instruction (instr1),
        .i_ready       (ready1),
        .i_stall       (stall1),
        .o_last_instr  (last1),
        .i_log_rd_idx  (rd_idx1),
        .o_log_rd_data (rd_data1),
        .o_log_count   (cnt1),
        .o_log_ovf     (ovf1),
        .o_done        (done1),
        .o_timeout_err (err1)
    );

    fetch_stim_gen #(
        .NUM_REQ  (10),
        .START_PC (32'hFFFF_FFFC)
    ) dut2 (
        .i_clk         (clk),
        .i_rst         (rst2),
        .o_core_rst    (core_rst2),
        .o_pc          (pc2),
        .o_req         (req2),
        .i_instruction (instr2),
        .i_ready       (ready2),
        .i_stall       (1'b0),
        .o_last_instr  (last2),
        .i_log_rd_idx  (rd_idx2),
        .o_log_rd_data (rd_data2),
        .o_log_count   (cnt2),
        .o_log_ovf     (ovf2),
        .o_done        (done2),
        .o_timeout_err (err2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: a falling req marks a completed (or timed-out) fetch.
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst1 && prev1 && !req1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_completion", 64'(pc1), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q1.pop_front();
                check("dut1_pc", 64'(pc1), 64'(e.pc));
                check("dut1_last_instr", 64'(last1), 64'(e.instr));
                check("dut1_done", 64'(done1), 64'(e.done));
                check("dut1_timeout_err", 64'(err1), 64'(e.err));
            end
        end
        prev1 = rst1 ? 1'b0 : req1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst2 && prev2 && !req2) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_completion", 64'(pc2), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q2.pop_front();
                check("dut2_pc", 64'(pc2), 64'(e.pc));
                check("dut2_last_instr", 64'(last2), 64'(e.instr));
                check("dut2_done", 64'(done2), 64'(e.done));
                check("dut2_timeout_err", 64'(err2), 64'(e.err));
            end
        end
        prev2 = rst2 ? 1'b0 : req2;
    end

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals1();
        rd_idx1 = 3'd0;
        #1;
        check("rst_core_rst", 64'(core_rst1), 64'd1);
        check("rst_pc", 64'(pc1), 64'd0);
        check("rst_req", 64'(req1), 64'd0);
        check("rst_last_instr", 64'(last1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_timeout_err", 64'(err1), 64'd0);
        check("rst_log_count", 64'(cnt1), 64'd0);
        check("rst_log_ovf", 64'(ovf1), 64'd0);
        check("rst_log_rd_data", 64'(rd_data1), 64'd0);
    endtask

    // Reset, release, then check core_rst falls after exactly 5 edges and req one cycle later.
    task automatic release_reset1();
        rst1   = 1'b1;
        ready1 = 1'b0;
        stall1 = 1'b0;
        check_reset_vals1();
        step1();
        rst1 = 1'b0;
        repeat (4) step1();
        check("core_rst_edge4", 64'(core_rst1), 64'd1);
        step1();
        check("core_rst_edge5", 64'(core_rst1), 64'd0);
        check("req_edge5", 64'(req1), 64'd0);
        step1();
        check("req_edge6", 64'(req1), 64'd1);
        check("pc_first_issue", 64'(pc1), 64'd0);
    endtask

    task automatic wait_req1();
        int c = 0;
        while (!req1 && c < 100) begin
            step1();
            c++;
        end
        check("dut1_req_wait", 64'(req1), 64'd1);
    endtask

    task automatic fetch1(input logic [31:0] ins, input logic [31:0] exp_pc, input logic last);
        exp_t e;
        wait_req1();
        repeat (3) step1();
        ready1 = 1'b1;
        instr1 = ins;
        e = '{pc: exp_pc, instr: ins, done: last, err: 1'b0};
        q1.push_back(e);
        step1();
        ready1 = 1'b0;
    endtask

    task automatic default_run1();
        release_reset1();
        for (int n = 0; n < 4; n++) begin
            fetch1(32'h13 + 32'(n), 32'(4 * (n + 1)), (n == 3));
        end
        repeat (2) step1();
        check("default_done", 64'(done1), 64'd1);
        check("default_timeout_err", 64'(err1), 64'd0);
        check("default_req_low", 64'(req1), 64'd0);
`ifdef FETCH_STIM_LOG_EN
        check("default_log_count", 64'(cnt1), 64'd4);
        check("default_log_ovf", 64'(ovf1), 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd_idx1 = 3'(i);
            #1;
            check("default_log_entry", 64'(rd_data1), 64'(32'h13 + 32'(i)));
        end
`else
        check("default_log_count_off", 64'(cnt1), 64'd0);
        rd_idx1 = 3'd1;
        #1;
        check("default_log_rd_off", 64'(rd_data1), 64'd0);
`endif
    endtask

    initial begin
        exp_t e;
        // Default run with reset sequencing
        repeat (2) step1();
        default_run1();

        // Mid-operation reset during WAIT of fetch 2, then a full run
        release_reset1();
        fetch1(32'h13, 32'h4, 1'b0);
        wait_req1();
        step1();
        rst1 = 1'b1;
        check_reset_vals1();
        repeat (2) step1();
        default_run1();

        // Timeout with 10 stalled WAIT cycles: ERR after exactly 64 unstalled cycles
        release_reset1();
        stall1 = 1'b1;
        repeat (10) step1();
        stall1 = 1'b0;
        repeat (63) step1();
        check("timeout_not_yet_req", 64'(req1), 64'd1);
        check("timeout_not_yet_done", 64'(done1), 64'd0);
        e = '{pc: 32'h0, instr: 32'h0, done: 1'b1, err: 1'b1};
        q1.push_back(e);
        step1();
        check("timeout_done", 64'(done1), 64'd1);
        check("timeout_err", 64'(err1), 64'd1);
        check("timeout_pc", 64'(pc1), 64'd0);
        repeat (3) step1();
        check("timeout_pc_frozen", 64'(pc1), 64'd0);
        check("timeout_req_low", 64'(req1), 64'd0);

        // Ready rise on the timeout cycle captures with no error
        release_reset1();
        repeat (63) step1();
        ready1 = 1'b1;
        instr1 = 32'h0000_CAFE;
        e = '{pc: 32'h4, instr: 32'h0000_CAFE, done: 1'b0, err: 1'b0};
        q1.push_back(e);
        step1();
        check("race_timeout_err", 64'(err1), 64'd0);
        check("race_done", 64'(done1), 64'd0);
        // Ready held high into the next WAIT must not capture
        wait_req1();
        repeat (3) step1();
        check("held_ready_no_capture", 64'(last1), 64'h0000_CAFE);
        check("held_ready_req", 64'(req1), 64'd1);
        ready1 = 1'b0;
        step1();
        ready1 = 1'b1;
        instr1 = 32'h0000_BEEF;
        e = '{pc: 32'h8, instr: 32'h0000_BEEF, done: 1'b0, err: 1'b0};
        q1.push_back(e);
        step1();
        ready1 = 1'b0;
        repeat (2) step1();

        // Wrap instance: PC wraps through 0 and the log overflows
        rst2 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            int c = 0;
            while (!req2 && c < 100) begin
                step1();
                c++;
            end
            check("dut2_req_wait", 64'(req2), 64'd1);
            if (n == 2) check("wrap_second_pc", 64'(pc2), 64'd0);
            ready2 = 1'b1;
            instr2 = 32'hA0 + 32'(n);
            e = '{pc: 32'hFFFF_FFFC + 32'(4 * n), instr: 32'hA0 + 32'(n), done: (n == 10),
                  err: 1'b0};
            q2.push_back(e);
            step1();
            ready2 = 1'b0;
        end
        repeat (2) step1();
        check("wrap_done", 64'(done2), 64'd1);
        check("wrap_timeout_err", 64'(err2), 64'd0);
`ifdef FETCH_STIM_LOG_EN
        check("wrap_log_ovf", 64'(ovf2), 64'd1);
        check("wrap_log_count", 64'(cnt2), 64'd8);
        rd_idx2 = 3'd0;
        #1;
        check("wrap_log_idx0", 64'(rd_data2), 64'hA9);
        rd_idx2 = 3'd1;
        #1;
        check("wrap_log_idx1", 64'(rd_data2), 64'hAA);
        rd_idx2 = 3'd2;
        #1;
        check("wrap_log_idx2", 64'(rd_data2), 64'hA3);
`else
        check("wrap_log_ovf_off", 64'(ovf2), 64'd0);
        check("wrap_log_count_off", 64'(cnt2), 64'd0);
`endif

        step1();
        check("dut1_queue_drained", 64'(q1.size()), 64'd0);
        check("dut2_queue_drained", 64'(q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_stim_gen.md
# fetch_stim_gen

Synthesisable fetch-stimulus sequencer for the instruction-fetch path. It sequences core reset, issues a programmable series of fetch PCs, and waits for each `ready` rising edge. It captures every returned instruction into a readable log and flags completion or timeout. It sits between the bench top and the fetch unit under test, replacing hand-written reset/PC loops with a parametrised, cycle-exact driver.

## Interface
Parameters:
- `XLEN`, 32: PC and instruction width.
- `RESET_CYCLES`, 5: cycles `core_rst` is held after `rst` drops; must be at least 1.
- `NUM_REQ`, 4: fetches to issue; must be at least 1.
- `START_PC`, 0: first PC.
- `PC_STRIDE`, 4: PC increment per completed fetch.
- `GAP_CYCLES`, 2: idle cycles between a capture and the next issue; 0 is allowed.
- `TIMEOUT`, 64: maximum unstalled WAIT cycles; must be at least 1.
- `LOG_DEPTH`, 8: capture-log entries; must be a power of 2.

Ports:
- `clk`  in  1  clock; all flops rise-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `core_rst`  out  1  reset driven to the fetch unit.
- `pc`  out  XLEN  current fetch address.
- `req`  out  1  fetch request outstanding.
- `instruction`  in  XLEN  returned instruction word.
- `ready`  in  1  fetch-complete strobe; sampled on its rising edge.
- `stall`  in  1  fetch stalled; freezes the timeout timer.
- `last_instr`  out  XLEN  most recently captured instruction.
- `log_rd_idx`  in  $clog2(LOG_DEPTH)  log read index.
- `log_rd_data`  out  XLEN  log entry at `log_rd_idx`; combinational.
- `log_count`  out  $clog2(LOG_DEPTH)+1  valid entries, saturating at LOG_DEPTH.
- `log_ovf`  out  1  sticky; set when the log wrapped.
- `done`  out  1  sticky; sequence finished (normally or by timeout).
- `timeout_err`  out  1  sticky; a fetch timed out.

## Operation
States: RST_HOLD, ISSUE, WAIT, GAP, DONE, ERR.
- **RST_HOLD**: `core_rst`=1. Hold counter runs from 0 to RESET_CYCLES-1, then `core_rst`=0 and the FSM moves to ISSUE.
- **ISSUE** (1 cycle): `req`=1, `pc` stable, timeout timer cleared. Next state is WAIT.
- **WAIT**: `req`=1.
  - Capture fires when `ready`=1 and `ready_q`=0, where `ready_q` is `ready` registered on the previous cycle. `stall` does not block a capture.
  - On capture: `last_instr`←`instruction`, log write, `pc`←`pc`+PC_STRIDE (mod 2^XLEN), request index increments, `req`=0.
  - If the captured fetch is number NUM_REQ, go to DONE. Otherwise go to GAP, or straight to ISSUE when GAP_CYCLES=0.
  - The timer increments only on cycles with `stall`=0. When the timer reaches TIMEOUT without a capture, go to ERR.
- **GAP**: `req`=0 for GAP_CYCLES cycles, then ISSUE.
- **DONE**: `done`=1, `req`=0. Terminal until `rst`.
- **ERR**: `done`=1, `timeout_err`=1, `req`=0, `pc` frozen. Terminal until `rst`.
- **Log behaviour**:
  - The write pointer wraps modulo LOG_DEPTH.
  - A write into a full log overwrites the oldest entry and sets `log_ovf`.
  - `log_rd_data` returns the entry at `log_rd_idx`. Unwritten entries read 0.
- **Reset values**: `core_rst`=1, `pc`=START_PC, `req`=0, `last_instr`=0, `log_count`=0, `log_ovf`=0, `done`=0, `timeout_err`=0, `ready_q`=0, state RST_HOLD, log contents 0.
- **`rst` asserted mid-operation**: all outputs take their reset values immediately; the sequence restarts from RST_HOLD.

## Timing
- `core_rst` falls RESET_CYCLES rising edges after the first edge at which `rst`=0.
- `req` rises 1 cycle after `core_rst` falls.
- Capture latency: `last_instr` and `pc` update on the edge that samples the `ready` rise. `req` is low the following cycle.
- Issue-to-issue with an instant `ready` response is 2+GAP_CYCLES cycles.
- `ready` already high at entry to WAIT does not trigger a capture; a new rising edge is required.
- A `ready` rise on the same cycle as the timeout expiry counts as a capture; capture wins.

## Configuration
- `FETCH_STIM_LOG_EN` defined: capture-log RAM, pointer, `log_count` and `log_ovf` are implemented as described above.
- `FETCH_STIM_LOG_EN` undefined: no log storage. `log_rd_data`, `log_count` and `log_ovf` are tied to 0. `last_instr`, the FSM and all other behaviour are unchanged.

## Test plan
- **Default run**: defaults; bench raises `ready` 3 cycles after each `req` rise, `instruction`=0x00000013+n. Required: PCs 0x0, 0x4, 0x8, 0xC; `done`=1; log holds 0x13..0x16; `log_count`=4; `timeout_err`=0.
- **Reset sequencing**: `rst` released at cycle 0. Required: `core_rst` falls after exactly 5 edges; `req` rises 1 cycle later with `pc`=START_PC.
- **Timeout with stall**: `ready` never rises; `stall`=1 for 10 WAIT cycles, then 0. Required: ERR entered exactly 64 unstalled cycles after ISSUE; `done`=1, `timeout_err`=1, `pc`=0.
- **Log wrap**: NUM_REQ=10, LOG_DEPTH=8. Required: `log_ovf`=1, `log_count`=8, indices 0 and 1 hold instructions 9 and 10.
- **PC wrap and capture race**: START_PC=0xFFFFFFFC, NUM_REQ=2. Required: second `pc`=0x0. Separately, a `ready` rise on the timeout cycle must capture with no error.
- **Mid-operation reset**: pulse `rst` during WAIT of fetch 2. Required: all outputs return to reset values asynchronously, and a full default run then completes.
